// File: rtl/regalu_core_if.sv
// regalu_core_if
//    Command/result bundle between the top-level controller and regalu_core.
//    The controller (master) issues one command per cycle and reads back the
//    combinational result, the registered flags and the debug read port.
//
//    Signals:
//       wEnable   write alu_out into rd_idx at the next edge
//       ra_idx    operand A register index
//       rb_idx    operand B register index
//       rd_idx    destination register index
//       opcode    operation select
//       cin       carry/borrow in for ADDC/SUBC
//       immB      immediate operand
//       selB_imm  1: B = immB, 0: B = R[rb_idx]
//       dbg_idx   debug read index
//       alu_out   combinational result
//       flags     registered {C, L, F, Z, N}
//       dbg_q     R[dbg_idx], combinational
//       op_err    last edge saw an invalid opcode with wEnable set
interface regalu_core_if #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_IDX_W  = 4,
   parameter int ALU_OP_W   = 8
);
   logic                  wEnable;
   logic [REG_IDX_W-1:0]  ra_idx;
   logic [REG_IDX_W-1:0]  rb_idx;
   logic [REG_IDX_W-1:0]  rd_idx;
   logic [ALU_OP_W-1:0]   opcode;
   logic                  cin;
   logic [DATA_WIDTH-1:0] immB;
   logic                  selB_imm;
   logic [REG_IDX_W-1:0]  dbg_idx;
   logic [DATA_WIDTH-1:0] alu_out;
   logic [4:0]            flags;
   logic [DATA_WIDTH-1:0] dbg_q;
   logic                  op_err;

   // Controller side: issues commands, observes results.
   modport master (
      output wEnable, ra_idx, rb_idx, rd_idx, opcode, cin, immB, selB_imm, dbg_idx,
      input  alu_out, flags, dbg_q, op_err
   );

   // Core side: executes commands, returns results.
   modport slave (
      input  wEnable, ra_idx, rb_idx, rd_idx, opcode, cin, immB, selB_imm, dbg_idx,
      output alu_out, flags, dbg_q, op_err
   );
endinterface

// File: rtl/regalu_core.sv
// regalu_core
//    16-entry register file plus ALU. Each cycle the controller's command is
//    decoded combinationally: two operands are read, a result is produced on
//    alu_out, and at the next rising edge the result is optionally written
//    back and the flag register {C, L, F, Z, N} is updated.
//
//    Ports:
//       clk   clock, all state updates on the rising edge
//       rst   asynchronous, active-high reset (clears registers, flags, op_err)
//       bus   regalu_core_if.slave command/result bundle
//
//    Optional feature: define REGALU_MUL_EN to enable opcode 0E (low half of
//    the unsigned product A * B). Without it, 0E decodes as invalid.
module regalu_core #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_IDX_W  = 4,
   parameter int ALU_OP_W   = 8
) (
   input logic          clk,
   input logic          rst,
   regalu_core_if.slave bus
);

   localparam int NREGS = 1 << REG_IDX_W;
   localparam int MSB   = DATA_WIDTH - 1;

   localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(8'h01);
   localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(8'h02);
   localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(8'h03);
   localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(8'h05);
   localparam logic [ALU_OP_W-1:0] OP_ADDU = ALU_OP_W'(8'h06);
   localparam logic [ALU_OP_W-1:0] OP_ADDC = ALU_OP_W'(8'h07);
   localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(8'h09);
   localparam logic [ALU_OP_W-1:0] OP_SUBC = ALU_OP_W'(8'h0A);
   localparam logic [ALU_OP_W-1:0] OP_CMP  = ALU_OP_W'(8'h0B);
   localparam logic [ALU_OP_W-1:0] OP_MOV  = ALU_OP_W'(8'h0D);
`ifdef REGALU_MUL_EN
   localparam logic [ALU_OP_W-1:0] OP_MUL  = ALU_OP_W'(8'h0E);
`endif
   localparam logic [ALU_OP_W-1:0] OP_LSH  = ALU_OP_W'(8'h84);

   logic [DATA_WIDTH-1:0] regs [NREGS];

   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic [DATA_WIDTH-1:0] result;
   logic [DATA_WIDTH:0]   wide;
   logic                  valid;
   logic                  is_cmp;
   logic                  upd_c;
   logic                  upd_f;
   logic                  ovf;
   logic                  cmp_l;
   logic                  cmp_n;
   logic                  cmp_z;

   logic c_q, l_q, f_q, z_q, n_q;
   logic op_err_q;

   // Operand fetch and ALU decode. Arithmetic runs one bit wider than the
   // data path so the carry/borrow falls out in the top bit of 'wide'.
   // CMP and invalid opcodes leave result at zero, which is what alu_out shows.
   always_comb begin
      op_a   = regs[bus.ra_idx];
      op_b   = bus.selB_imm ? bus.immB : regs[bus.rb_idx];
      result = '0;
      wide   = '0;
      valid  = 1'b1;
      is_cmp = 1'b0;
      upd_c  = 1'b0;
      upd_f  = 1'b0;
      ovf    = 1'b0;
      cmp_l  = op_b < op_a;
      cmp_n  = $signed(op_b) < $signed(op_a);
      cmp_z  = op_a == op_b;
      case (bus.opcode)
         OP_AND: result = op_a & op_b;
         OP_OR:  result = op_a | op_b;
         OP_XOR: result = op_a ^ op_b;
         OP_ADD, OP_ADDU, OP_ADDC: begin
            wide   = {1'b0, op_a} + {1'b0, op_b}
                   + {{DATA_WIDTH{1'b0}}, (bus.opcode == OP_ADDC) & bus.cin};
            result = wide[MSB:0];
            upd_c  = 1'b1;
            upd_f  = bus.opcode != OP_ADDU;
            ovf    = (op_a[MSB] == op_b[MSB]) && (result[MSB] != op_a[MSB]);
         end
         OP_SUB, OP_SUBC: begin
            wide   = {1'b0, op_a} - {1'b0, op_b}
                   - {{DATA_WIDTH{1'b0}}, (bus.opcode == OP_SUBC) & bus.cin};
            result = wide[MSB:0];
            upd_c  = 1'b1;
            upd_f  = 1'b1;
            ovf    = (op_a[MSB] != op_b[MSB]) && (result[MSB] != op_a[MSB]);
         end
         OP_CMP: is_cmp = 1'b1;
         OP_MOV: result = op_b;
`ifdef REGALU_MUL_EN
         OP_MUL: result = op_a * op_b;
`endif
         // B[4] picks direction, B[3:0] is the distance; right shift is logical.
         OP_LSH: result = op_b[4] ? (op_a >> op_b[3:0]) : (op_a << op_b[3:0]);
         default: valid = 1'b0;
      endcase
   end

   // Register file, flags and error bit. CMP updates flags even without
   // wEnable but never writes a register; C and F only move on arithmetic
   // ops, L only on CMP. An invalid opcode leaves everything but op_err alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         c_q      <= 1'b0;
         l_q      <= 1'b0;
         f_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         op_err_q <= 1'b0;
      end else begin
         op_err_q <= bus.wEnable & ~valid;
         if (bus.wEnable && valid && !is_cmp) begin
            regs[bus.rd_idx] <= result;
         end
         if (valid && (bus.wEnable || is_cmp)) begin
            if (is_cmp) begin
               l_q <= cmp_l;
               z_q <= cmp_z;
               n_q <= cmp_n;
            end else begin
               z_q <= result == '0;
               n_q <= result[MSB];
               if (upd_c) c_q <= wide[DATA_WIDTH];
               if (upd_f) f_q <= ovf;
            end
         end
      end
   end

   assign bus.alu_out = result;
   assign bus.flags   = {c_q, l_q, f_q, z_q, n_q};
   assign bus.dbg_q   = regs[bus.dbg_idx];
   assign bus.op_err  = op_err_q;

endmodule
